// File: rtl/button_conditioner_pkg.sv
// Shared state encoding and default timing values for the button conditioner.
package button_conditioner_pkg;

    localparam logic [1:0] ST_STABLE_LOW  = 2'd0;
    localparam logic [1:0] ST_PEND_HIGH   = 2'd1;
    localparam logic [1:0] ST_STABLE_HIGH = 2'd2;
    localparam logic [1:0] ST_PEND_LOW    = 2'd3;

    typedef enum logic [1:0] {
        STABLE_LOW  = ST_STABLE_LOW,
        PEND_HIGH   = ST_PEND_HIGH,
        STABLE_HIGH = ST_STABLE_HIGH,
        PEND_LOW    = ST_PEND_LOW
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int LONG_CYCLES_DEF     = 100000000;

endpackage

// File: rtl/button_conditioner_if.sv
// Raw buttons in, conditioned levels/pulses out, plus per-channel FSM state for observation.
// start_long exists only when LONG_PRESS_EN is defined.
interface button_conditioner_if;
    import button_conditioner_pkg::*;

    logic   start_raw;
    logic   clear_raw;
    logic   startbutton;
    logic   reset;
    logic   start_press;
    logic   start_release;
    logic   clear_press;
    logic   clear_release;
    state_t start_state;
    state_t clear_state;
`ifdef LONG_PRESS_EN
    logic   start_long;
`endif

    // Buttons are plain levels and pulses: no valid/ready pairing, every output is
    // meaningful on every clock and pulses are exactly one clock wide.
    modport master (
        output start_raw, clear_raw,
        input  startbutton, reset, start_press, start_release, clear_press,
        input  clear_release, start_state, clear_state
`ifdef LONG_PRESS_EN
        , input start_long
`endif
    );

    modport slave (
        input  start_raw, clear_raw,
        output startbutton, reset, start_press, start_release, clear_press,
        output clear_release, start_state, clear_state
`ifdef LONG_PRESS_EN
        , output start_long
`endif
    );

endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One button: SYNC_STAGES synchronizer, four-state debounce FSM, saturating
// stable-clock count, and registered press/release pulses.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   raw,
    output logic   level,
    output logic   rise_pulse,
    output logic   fall_pulse,
    output state_t state
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 24'hFF_FFFF) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("SYNC_STAGES out of range");
    end

    // The clock that leaves STABLE already saw the new value, so it is the first
    // of the DEBOUNCE_CYCLES stable clocks; count==N means N+1 seen so far.
    localparam logic [23:0] ACCEPT_AT = 24'(DEBOUNCE_CYCLES - 2);
    localparam logic [23:0] COUNT_MAX = 24'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    state_t                 state_q, state_d;
    logic [23:0]            count_q, count_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            state_q <= STABLE_LOW;
            count_q <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            state_q <= state_d;
            count_q <= count_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (synced) begin
                    state_d = PEND_HIGH;
                    count_d = '0;
                end
            end
            PEND_HIGH: begin
                if (!synced) begin
                    state_d = STABLE_LOW;
                    count_d = '0;
                end else if (count_q == ACCEPT_AT) begin
                    state_d = STABLE_HIGH;
                    count_d = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else if (count_q != COUNT_MAX) begin
                    count_d = count_q + 24'd1;
                end
            end
            STABLE_HIGH: begin
                if (!synced) begin
                    state_d = PEND_LOW;
                    count_d = '0;
                end
            end
            PEND_LOW: begin
                if (synced) begin
                    state_d = STABLE_HIGH;
                    count_d = '0;
                end else if (count_q == ACCEPT_AT) begin
                    state_d = STABLE_LOW;
                    count_d = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else if (count_q != COUNT_MAX) begin
                    count_d = count_q + 24'd1;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                count_d = '0;
            end
        endcase
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign state      = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the start and clear pushbuttons into levels and one-clock pulses.
// Define LONG_PRESS_EN to add the start_long hold-detect pulse.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input logic                clk,
    input logic                reset_n,
    button_conditioner_if.slave bus
);

    if (LONG_CYCLES < 1 || LONG_CYCLES > 28'hFFF_FFFE) begin : g_bad_long
        $error("LONG_CYCLES out of range");
    end

    logic start_level;

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_start (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw       (bus.start_raw),
        .level     (start_level),
        .rise_pulse(bus.start_press),
        .fall_pulse(bus.start_release),
        .state     (bus.start_state)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_clear (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw       (bus.clear_raw),
        .level     (bus.reset),
        .rise_pulse(bus.clear_press),
        .fall_pulse(bus.clear_release),
        .state     (bus.clear_state)
    );

    assign bus.startbutton = start_level;

`ifdef LONG_PRESS_EN
    // Hold counter saturates one past the fire point so the pulse fires once per press.
    localparam logic [27:0] LONG_LAST = 28'(LONG_CYCLES - 1);
    localparam logic [27:0] LONG_SAT  = 28'(LONG_CYCLES);

    logic [27:0] hold_q;
    logic        long_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= start_level && (hold_q == LONG_LAST);
            if (!start_level) begin
                hold_q <= '0;
            end else if (hold_q != LONG_SAT) begin
                hold_q <= hold_q + 28'd1;
            end
        end
    end

    assign bus.start_long = long_q;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, LONG_CYCLES=10.
// Output vector order: {startbutton, reset, start_press, start_release, clear_press}.
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    localparam int DEB  = 4;
    localparam int SYN  = 2;
    localparam int LONG = 10;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    logic [4:0] exp_q[$];

    button_conditioner_if bus();

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYN),
        .LONG_CYCLES    (LONG)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] outs();
        return {bus.startbutton, bus.reset, bus.start_press, bus.start_release, bus.clear_press};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Driver: apply inputs for one rising edge, then score the outputs of that edge.
    task automatic step(input logic s, input logic c, input logic [4:0] exp, input string name);
        logic [4:0] e;
        @(negedge clk);
        bus.start_raw = s;
        bus.clear_raw = c;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(name, 32'(outs()), 32'(e));
    endtask

    typedef struct {
        logic       s;
        logic       c;
        int         n;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus.start_raw = 1'b0;
        bus.clear_raw = 1'b0;

        // Press, hold, release of start
        vecs.push_back('{1'b1, 1'b0, 5, 5'b00000});
        vecs.push_back('{1'b1, 1'b0, 1, 5'b10100});
        vecs.push_back('{1'b1, 1'b0, 3, 5'b10000});
        vecs.push_back('{1'b0, 1'b0, 5, 5'b10000});
        vecs.push_back('{1'b0, 1'b0, 1, 5'b00010});
        vecs.push_back('{1'b0, 1'b0, 3, 5'b00000});
        // High for DEBOUNCE_CYCLES-1 clocks only: rejected
        vecs.push_back('{1'b1, 1'b0, 3, 5'b00000});
        vecs.push_back('{1'b0, 1'b0, 8, 5'b00000});
        // Bounce 1,0,1,0 then held: timed from the final rise
        vecs.push_back('{1'b1, 1'b0, 1, 5'b00000});
        vecs.push_back('{1'b0, 1'b0, 1, 5'b00000});
        vecs.push_back('{1'b1, 1'b0, 1, 5'b00000});
        vecs.push_back('{1'b0, 1'b0, 1, 5'b00000});
        vecs.push_back('{1'b1, 1'b0, 5, 5'b00000});
        vecs.push_back('{1'b1, 1'b0, 1, 5'b10100});
        vecs.push_back('{1'b1, 1'b0, 2, 5'b10000});
        vecs.push_back('{1'b0, 1'b0, 5, 5'b10000});
        vecs.push_back('{1'b0, 1'b0, 1, 5'b00010});
        vecs.push_back('{1'b0, 1'b0, 2, 5'b00000});
        // Both buttons together
        vecs.push_back('{1'b1, 1'b1, 5, 5'b00000});
        vecs.push_back('{1'b1, 1'b1, 1, 5'b11101});
        vecs.push_back('{1'b1, 1'b1, 2, 5'b11000});
        vecs.push_back('{1'b0, 1'b0, 5, 5'b11000});
        vecs.push_back('{1'b0, 1'b0, 1, 5'b00010});
        vecs.push_back('{1'b0, 1'b0, 2, 5'b00000});
        // Staggered: clear two clocks after start, each on its own schedule
        vecs.push_back('{1'b1, 1'b0, 2, 5'b00000});
        vecs.push_back('{1'b1, 1'b1, 3, 5'b00000});
        vecs.push_back('{1'b1, 1'b1, 1, 5'b10100});
        vecs.push_back('{1'b1, 1'b1, 1, 5'b10000});
        vecs.push_back('{1'b1, 1'b1, 1, 5'b11001});
        vecs.push_back('{1'b1, 1'b1, 2, 5'b11000});
        vecs.push_back('{1'b0, 1'b0, 5, 5'b11000});
        vecs.push_back('{1'b0, 1'b0, 1, 5'b00010});
        vecs.push_back('{1'b0, 1'b0, 2, 5'b00000});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(outs()), 32'd0);
        check("reset_start_state", 32'(bus.start_state), 32'(STABLE_LOW));
        check("reset_clear_state", 32'(bus.clear_state), 32'(STABLE_LOW));
        @(posedge clk);
        #3;
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                step(vecs[i].s, vecs[i].c, vecs[i].exp, $sformatf("vec%0d_cyc%0d", i, k));
            end
        end

        // Asynchronous reset with start accepted and clear pending at count 2
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 5'b00000, $sformatf("pre_rst_a%0d", k));
        step(1'b1, 1'b0, 5'b10100, "pre_rst_accept");
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 5'b10000, $sformatf("pre_rst_b%0d", k));
        check("clear_pend_high", 32'(bus.clear_state), 32'(PEND_HIGH));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_outputs", 32'(outs()), 32'd0);
        check("async_rst_start_state", 32'(bus.start_state), 32'(STABLE_LOW));
        check("async_rst_clear_state", 32'(bus.clear_state), 32'(STABLE_LOW));
        @(posedge clk);
        @(posedge clk);
        #1;
        check("held_rst_outputs", 32'(outs()), 32'd0);
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 5'b00000, $sformatf("post_rst%0d", k));
        step(1'b1, 1'b1, 5'b11101, "post_rst_accept");
        step(1'b1, 1'b1, 5'b11000, "post_rst_hold");

`ifdef LONG_PRESS_EN
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 5'b11000, $sformatf("lp_rel%0d", k));
        step(1'b0, 1'b0, 5'b00010, "lp_rel_pulse");
        step(1'b0, 1'b0, 5'b00000, "lp_idle");
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 5'b00000, $sformatf("lp%0d_pend%0d", r, k));
            step(1'b1, 1'b0, 5'b10100, $sformatf("lp%0d_accept", r));
            check($sformatf("lp%0d_long_at_accept", r), 32'(bus.start_long), 32'd0);
            for (int k = 1; k <= 13; k++) begin
                step(1'b1, 1'b0, 5'b10000, $sformatf("lp%0d_hold%0d", r, k));
                check($sformatf("lp%0d_long%0d", r, k), 32'(bus.start_long), (k == LONG) ? 32'd1 : 32'd0);
            end
            for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 5'b10000, $sformatf("lp%0d_rel%0d", r, k));
            step(1'b0, 1'b0, 5'b00010, $sformatf("lp%0d_rel_pulse", r));
            check($sformatf("lp%0d_long_after_rel", r), 32'(bus.start_long), 32'd0);
            step(1'b0, 1'b0, 5'b00000, $sformatf("lp%0d_idle", r));
        end
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL be the number of consecutive stable clocks required to accept an input change (range 2..2^24-1).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL be the synchronizer depth per raw input (2..3).
REQ-003 Parameter LONG_CYCLES, default 100000000, SHALL be the hold time for a long press (used only under REQ-022).
REQ-004 clk  in  1  SHALL be the single clock; every flop is on its rising edge.
REQ-005 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 start_raw  in  1  SHALL be the raw, bouncing start pushbutton.
REQ-007 clear_raw  in  1  SHALL be the raw, bouncing reset/clear pushbutton.
REQ-008 startbutton  out  1  SHALL be the debounced start level that feeds the counter's startbutton input.
REQ-009 reset  out  1  SHALL be the debounced clear level that feeds the counter's reset input.
REQ-010 start_press, start_release  out  1 each  SHALL be one-clock pulses on accepted start press/release.
REQ-011 clear_press  out  1  SHALL be a one-clock pulse on accepted clear press.

Function
REQ-012 Each button SHALL pass through SYNC_STAGES flops, then a per-channel FSM with states STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW.
REQ-013 STABLE_x SHALL move to PEND_y, and load count=0, on the first clock where the synced value differs from the stable level.
REQ-014 PEND_y SHALL increment count each clock that the synced value still equals y.
REQ-015 On the edge where count==DEBOUNCE_CYCLES-1 and the synced value is still y, the FSM SHALL enter STABLE_y and update the level output.
REQ-016 If the synced value reverts during PEND_y, the FSM SHALL return to STABLE_x, clear count and leave the level unchanged; there is no partial credit.
REQ-017 Level latency SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges from the first edge that samples a clean raw change.
REQ-018 The press/release pulse SHALL assert in the same cycle the level changes and SHALL last exactly one clock.
REQ-019 The count register SHALL be 24 bits and SHALL never wrap; count saturates at DEBOUNCE_CYCLES-1.
REQ-020 Channels SHALL be fully independent; simultaneous changes on both buttons SHALL each be accepted on their own schedule.

Reset
REQ-021 While reset_n=0, all synchronizer flops, counts and levels SHALL be 0, FSMs SHALL be in STABLE_LOW and all pulses SHALL be 0, asynchronously; after deassertion a button already held SHALL be accepted after the full REQ-017 latency.

Configuration
REQ-022 With LONG_PRESS_EN defined:
- the start channel SHALL add output start_long (1 bit);
- start_long SHALL pulse one clock when startbutton has been continuously high for LONG_CYCLES clocks after acceptance;
- the pulse SHALL fire once per press, with a non-wrapping 28-bit hold counter cleared on release.
REQ-023 Without LONG_PRESS_EN, the start_long port and its counter SHALL be absent.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding (2-bit localparams) and default DEBOUNCE_CYCLES/SYNC_STAGES values.
REQ-025 One sub-module, debounce_channel (synchronizer + FSM + count + pulse), SHALL be instantiated twice.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, LONG_CYCLES=10)
REQ-026 start_raw 0->1 held -> startbutton=1 and start_press=1 for one cycle, exactly 6 edges later.
REQ-027 start_raw high 3 clocks then low -> startbutton stays 0 and no pulse.
REQ-028 start_raw bounce 1,0,1,0,1 (1 clock each) then held high -> acceptance 6 edges after the final rise only.
REQ-029 start_raw and clear_raw rise together -> startbutton and reset both rise 6 edges later, each pulse a single cycle.
REQ-030 reset_n pulsed low while in PEND_HIGH with count=2 -> outputs 0 immediately; held button accepted 6 edges after release.
REQ-031 LONG_PRESS_EN defined, button held -> start_long single pulse 10 clocks after startbutton rises; none while still held; re-arms after release.
